// File: rtl/master_req_queue.sv
// Request FIFO plus single-outstanding issue FSM in front of a master_port device interface.
// Read data is returned on a held response register that blocks further reads until consumed.
module master_req_queue #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int PTR_W      = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  qvalid,
  output logic                  qready,
  input  logic [ADDR_WIDTH-1:0] qaddr,
  input  logic [DATA_WIDTH-1:0] qwdata,
  input  logic                  qmode,
  output logic [ADDR_WIDTH-1:0] daddr,
  output logic [DATA_WIDTH-1:0] dwdata,
  output logic                  dmode,
  output logic                  dvalid,
  input  logic                  dready,
  input  logic [DATA_WIDTH-1:0] drdata,
  output logic                  rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  input  logic                  rready,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] fifo_addr_q  [DEPTH];
  logic [DATA_WIDTH-1:0] fifo_wdata_q [DEPTH];
  logic                  fifo_mode_q  [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_d;

  logic [ADDR_WIDTH-1:0] daddr_q, daddr_d;
  logic [DATA_WIDTH-1:0] dwdata_q, dwdata_d;
  logic                  dmode_q, dmode_d;
  logic                  dvalid_q, dvalid_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic push, pop;
  logic not_empty;
  logic head_mode;

  // qready comes only from the registered count, so a pop in the same cycle never frees a full slot
  assign qready    = (count_q != (PTR_W+1)'(DEPTH));
  assign not_empty = (count_q != '0);
  assign push      = qvalid && qready;
  assign head_mode = fifo_mode_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q]  <= qaddr;
      fifo_wdata_q[wr_ptr_q] <= qwdata;
      fifo_mode_q[wr_ptr_q]  <= qmode;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    daddr_d  = daddr_q;
    dwdata_d = dwdata_q;
    dmode_d  = dmode_q;
    dvalid_d = dvalid_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    pop      = 1'b0;

    if (rvalid_q && rready) rvalid_d = 1'b0;

    case (state_q)
      IDLE: begin
        // A read waits while an unconsumed response is held, so rdata is never overwritten
        if (not_empty && dready && !(!head_mode && rvalid_q)) begin
          pop      = 1'b1;
          daddr_d  = fifo_addr_q[rd_ptr_q];
          dwdata_d = fifo_wdata_q[rd_ptr_q];
          dmode_d  = head_mode;
          dvalid_d = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (!dready) begin
          dvalid_d = 1'b0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (dready) begin
          if (!dmode_q) begin
            rdata_d  = drdata;
            rvalid_d = 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: begin
        dvalid_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      daddr_q  <= '0;
      dwdata_q <= '0;
      dmode_q  <= 1'b0;
      dvalid_q <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      daddr_q  <= daddr_d;
      dwdata_q <= dwdata_d;
      dmode_q  <= dmode_d;
      dvalid_q <= dvalid_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign daddr  = daddr_q;
  assign dwdata = dwdata_q;
  assign dmode  = dmode_q;
  assign dvalid = dvalid_q;
  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;
  assign busy   = not_empty || (state_q != IDLE);

endmodule

// File: tb/tb_master_req_queue.sv
// Bench for master_req_queue: behavioural master_port/slave model on the device side,
// expected issue and read-response scoreboards checked by independent monitors.
module tb_master_req_queue;

  logic        clk = 1'b0;
  logic        rstn;
  logic        qvalid;
  logic        qready;
  logic [15:0] qaddr;
  logic [7:0]  qwdata;
  logic        qmode;
  logic [15:0] daddr;
  logic [7:0]  dwdata;
  logic        dmode;
  logic        dvalid;
  logic        dready;
  logic [7:0]  drdata;
  logic        rvalid;
  logic [7:0]  rdata;
  logic        rready;
  logic        busy;

  master_req_queue #(
    .ADDR_WIDTH(16),
    .DATA_WIDTH(8),
    .DEPTH(4),
    .PTR_W(2)
  ) dut (
    .clk(clk), .rstn(rstn),
    .qvalid(qvalid), .qready(qready), .qaddr(qaddr), .qwdata(qwdata), .qmode(qmode),
    .daddr(daddr), .dwdata(dwdata), .dmode(dmode), .dvalid(dvalid), .dready(dready),
    .drdata(drdata), .rvalid(rvalid), .rdata(rdata), .rready(rready), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int issues = 0;

  logic [24:0] exp_issue[$];  // {mode, addr, wdata}
  logic [7:0]  exp_rd[$];

  // Device-side model: master_port + slave memory
  logic [7:0]  mem [0:65535];
  logic        bus_stall = 1'b0;
  logic        mdl_busy  = 1'b0;
  logic        mdl_dready = 1'b1;
  int          grant_lat = 1;
  int          busy_lat  = 2;
  int          mst = 0;
  int          mcnt = 0;
  logic [15:0] ma;
  logic [7:0]  mw;
  logic        mm;

  assign dready = mdl_busy ? mdl_dready : !bus_stall;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0123] = 8'h77;
    drdata = 8'h00;
    forever begin
      @(negedge clk);
      case (mst)
        0: if (dvalid) begin
          ma = daddr; mw = dwdata; mm = dmode;
          mdl_busy = 1'b1; mdl_dready = 1'b1; mcnt = grant_lat; mst = 1;
        end
        1: if (mcnt == 0) begin
          mdl_dready = 1'b0; mcnt = busy_lat; mst = 2;
        end else mcnt--;
        2: if (mcnt == 0) begin
          if (mm) mem[ma] = mw; else drdata = mem[ma];
          mdl_dready = 1'b1; mst = 3;
        end else mcnt--;
        default: begin
          mdl_busy = 1'b0; mst = 0;
        end
      endcase
    end
  end

  // Issue monitor: every dvalid rising edge must match the oldest pushed request
  logic prev_dvalid = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (dvalid && !prev_dvalid) begin
        issues++;
        if (exp_issue.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_issue actual=0x%0h expected=none", {dmode, daddr, dwdata});
        end else begin
          check("issue_order", {7'd0, dmode, daddr, dwdata}, {7'd0, exp_issue.pop_front()});
        end
      end
      prev_dvalid = dvalid;
    end
  end

  // Response monitor: every new rvalid must carry the next expected read data
  logic prev_rvalid = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (rvalid && !prev_rvalid) begin
        if (exp_rd.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_response actual=0x%0h expected=none", rdata);
        end else begin
          check("read_data", {24'd0, rdata}, {24'd0, exp_rd.pop_front()});
        end
      end
      prev_rvalid = rvalid;
    end
  end

  task automatic push(input logic [15:0] a, input logic [7:0] w, input logic m, input logic [7:0] er);
    int unsigned n = 0;
    @(negedge clk);
    qaddr = a; qwdata = w; qmode = m; qvalid = 1'b1;
    while (!qready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!qready) begin
      checks++; errors++;
      $display("FAIL push_timeout actual=qready0 expected=qready1 addr=0x%0h", a);
    end else begin
      exp_issue.push_back({m, a, w});
      if (!m) exp_rd.push_back(er);
    end
    @(negedge clk);
    qvalid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int unsigned n = 0;
    while ((busy || mdl_busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (busy || mdl_busy) begin
      checks++; errors++;
      $display("FAIL %s_idle_timeout actual=busy expected=idle", tag);
    end
  endtask

  task automatic wait_rvalid(input string tag);
    int unsigned n = 0;
    while (!rvalid && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!rvalid) begin
      checks++; errors++;
      $display("FAIL %s_rvalid_timeout actual=0 expected=1", tag);
    end
  endtask

  int i0;

  initial begin
    rstn = 1'b0; qvalid = 1'b0; qaddr = '0; qwdata = '0; qmode = 1'b0; rready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_dvalid", {31'd0, dvalid}, 32'd0);
    check("rst_rvalid", {31'd0, rvalid}, 32'd0);
    check("rst_busy",   {31'd0, busy},   32'd0);
    check("rst_qready", {31'd0, qready}, 32'd1);
    check("rst_daddr",  {16'd0, daddr},  32'd0);
    check("rst_rdata",  {24'd0, rdata},  32'd0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // 1: write then read back, with first-issue latency
    i0 = issues;
    push(16'h00A5, 8'h3C, 1'b1, 8'h00);
    check("lat_edgeN_dvalid", {31'd0, dvalid}, 32'd0);
    @(negedge clk);
    check("lat_edgeN1_dvalid", {31'd0, dvalid}, 32'd1);
    push(16'h00A5, 8'h00, 1'b0, 8'h3C);
    wait_idle("t1");
    check("t1_mem", {24'd0, mem[16'h00A5]}, 32'h3C);
    check("t1_pulses", issues - i0, 2);

    // 2: fill the queue with the bus stalled; fifth request is held off
    @(negedge clk);
    bus_stall = 1'b1;
    push(16'h0010, 8'h11, 1'b1, 8'h00);
    push(16'h0011, 8'h22, 1'b1, 8'h00);
    push(16'h0012, 8'h33, 1'b1, 8'h00);
    check("t2_qready_cnt3", {31'd0, qready}, 32'd1);
    push(16'h0013, 8'h44, 1'b1, 8'h00);
    check("t2_qready_full", {31'd0, qready}, 32'd0);
    check("t2_busy",        {31'd0, busy},   32'd1);
    check("t2_no_dvalid",   {31'd0, dvalid}, 32'd0);
    qaddr = 16'h0014; qwdata = 8'h55; qmode = 1'b1; qvalid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("t2_holdoff_qready", {31'd0, qready}, 32'd0);
    end
    qvalid = 1'b0;
    bus_stall = 1'b0;
    push(16'h0014, 8'h55, 1'b1, 8'h00);
    wait_idle("t2");
    check("t2_mem_last", {24'd0, mem[16'h0014]}, 32'h55);

    // 3: held response blocks the next read, a write behind it still proceeds
    rready = 1'b0;
    push(16'h0011, 8'h00, 1'b0, 8'h22);
    push(16'h0020, 8'h5A, 1'b1, 8'h00);
    push(16'h00A5, 8'h00, 1'b0, 8'h3C);
    wait_rvalid("t3");
    i0 = issues;
    repeat (25) @(negedge clk);
    check("t3_rvalid_held", {31'd0, rvalid}, 32'd1);
    check("t3_rdata_stable", {24'd0, rdata}, 32'h22);
    check("t3_write_only", issues - i0, 1);
    check("t3_mem_write", {24'd0, mem[16'h0020]}, 32'h5A);
    check("t3_busy_blocked", {31'd0, busy}, 32'd1);
    rready = 1'b1;
    wait_idle("t3");

    // 4: location written by the other master, then overwritten by this queue
    push(16'h0123, 8'h00, 1'b0, 8'h77);
    push(16'h0123, 8'h78, 1'b1, 8'h00);
    push(16'h0123, 8'h00, 1'b0, 8'h78);
    wait_idle("t4");

    // 5: asynchronous reset while a transfer is in BUSY
    busy_lat = 20;
    push(16'h0030, 8'h99, 1'b1, 8'h00);
    begin
      int unsigned n = 0;
      while (!dvalid && n < 100) begin @(negedge clk); n++; end
      while (dvalid && n < 200) begin @(negedge clk); n++; end
      check("t5_reached_busy", {31'd0, busy && !dvalid}, 32'd1);
    end
    push(16'h00A5, 8'h00, 1'b0, 8'h3C);
    #3;
    rstn = 1'b0;
    #1;
    check("t5_async_dvalid", {31'd0, dvalid}, 32'd0);
    check("t5_async_rvalid", {31'd0, rvalid}, 32'd0);
    check("t5_async_busy",   {31'd0, busy},   32'd0);
    check("t5_async_qready", {31'd0, qready}, 32'd1);
    exp_issue.delete();
    exp_rd.delete();
    @(negedge clk);
    rstn = 1'b1;
    i0 = issues;
    repeat (30) @(negedge clk);
    check("t5_no_stale_issue", issues - i0, 0);
    check("t5_idle_after", {31'd0, busy}, 32'd0);
    wait_idle("t5");
    busy_lat = 2;

    // 6: push and pop in the same cycle at count 2
    @(negedge clk);
    bus_stall = 1'b1;
    push(16'h0040, 8'hA1, 1'b1, 8'h00);
    push(16'h0041, 8'hA2, 1'b1, 8'h00);
    check("t6_stalled", {31'd0, dvalid}, 32'd0);
    @(negedge clk);
    bus_stall = 1'b0;
    qaddr = 16'h0042; qwdata = 8'hA3; qmode = 1'b1; qvalid = 1'b1;
    check("t6_qready_cnt2", {31'd0, qready}, 32'd1);
    exp_issue.push_back({1'b1, 16'h0042, 8'hA3});
    @(negedge clk);
    qvalid = 1'b0;
    bus_stall = 1'b1;
    check("t6_pop_issued", {31'd0, dvalid}, 32'd1);
    push(16'h0043, 8'hA4, 1'b1, 8'h00);
    check("t6_qready_cnt3", {31'd0, qready}, 32'd1);
    push(16'h0044, 8'hA5, 1'b1, 8'h00);
    check("t6_qready_cnt4", {31'd0, qready}, 32'd0);
    @(negedge clk);
    bus_stall = 1'b0;
    wait_idle("t6");
    check("t6_mem_wrap", {24'd0, mem[16'h0044]}, 32'hA5);

    repeat (5) @(negedge clk);
    check("end_issue_queue_empty", exp_issue.size(), 0);
    check("end_resp_queue_empty", exp_rd.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

endmodule
